// File: rtl/ov7670_sccb_init_seq.sv
// ---------------------------------------------------------------------------
// ov7670_sccb_init_seq
//
// Register-initialisation sequencer for the OV7670 camera. After power-up it
// walks a fixed table of (register, value) pairs and issues each pair as one
// SCCB write through the i2c_master AXI-stream command and data interfaces.
// A table entry whose register is 8'hFF is a delay marker (used after the
// COM7 soft reset) and produces a wait instead of a write. An entry whose
// write is not acknowledged is retried up to MAX_RETRY times before the
// block gives up and reports an error.
//
// Ports:
//   clk, reset_            system clock, asynchronous active-low reset
//   start                  single-cycle pulse; reruns the table from index 0
//                          (honoured only while idle, done or in error)
//   cmd_*                  i2c_master s_axis_cmd_* (one write_multiple+stop
//                          command per table entry)
//   data_tdata/tvalid/
//   tready/tlast           i2c_master s_axis_data_* (register byte, then
//                          value byte with tlast)
//   i2c_busy               i2c_master busy
//   i2c_missed_ack         i2c_master missed_ack pulse
//   seq_busy               sequence in progress
//   seq_done               table completed without error (sticky)
//   seq_error              retries exhausted (sticky)
//   seq_index              current table index
// ---------------------------------------------------------------------------
module ov7670_sccb_init_seq #(
    parameter logic [6:0]  SLAVE_ADDR     = 7'h21,
    parameter int unsigned POWERUP_CYCLES = 1_000_000,
    parameter int unsigned SWRESET_CYCLES = 1_000_000,
    parameter int unsigned MAX_RETRY      = 3
) (
    input  logic       clk,
    input  logic       reset_,
    input  logic       start,
    output logic [6:0] cmd_address,
    output logic       cmd_start,
    output logic       cmd_read,
    output logic       cmd_write,
    output logic       cmd_write_multiple,
    output logic       cmd_stop,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic [7:0] data_tdata,
    output logic       data_tvalid,
    input  logic       data_tready,
    output logic       data_tlast,
    input  logic       i2c_busy,
    input  logic       i2c_missed_ack,
    output logic       seq_busy,
    output logic       seq_done,
    output logic       seq_error,
    output logic [3:0] seq_index
);

    localparam int unsigned MAX_WAIT = (POWERUP_CYCLES > SWRESET_CYCLES) ?
                                       POWERUP_CYCLES : SWRESET_CYCLES;
    localparam int unsigned CNT_W    = $clog2(MAX_WAIT) + 1;
    localparam int unsigned RETRY_W  = $clog2(MAX_RETRY + 1) + 1;

    localparam logic [CNT_W-1:0]   PWRUP_LAST   = CNT_W'(POWERUP_CYCLES - 1);
    localparam logic [CNT_W-1:0]   SWRST_LAST   = CNT_W'(SWRESET_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRY);
    localparam logic [3:0]         LAST_INDEX   = 4'd8;
    localparam logic [7:0]         DELAY_MARKER = 8'hFF;

    typedef enum logic [3:0] {
        IDLE       = 4'd0,
        PWRUP_WAIT = 4'd1,
        FETCH      = 4'd2,
        SEND_CMD   = 4'd3,
        SEND_REG   = 4'd4,
        SEND_VAL   = 4'd5,
        WAIT_BUSY  = 4'd6,
        CHECK      = 4'd7,
        DELAY      = 4'd8,
        DONE       = 4'd9,
        ERROR      = 4'd10
    } state_t;

    // Fixed initialisation table: {register, value}.
    function automatic logic [15:0] table_entry(input logic [3:0] idx);
        logic [15:0] entry;
        case (idx)
            4'd0:    entry = 16'h1280;  // COM7 soft reset
            4'd1:    entry = 16'hFFFF;  // delay marker: let the reset settle
            4'd2:    entry = 16'h1204;  // COM7: RGB output
            4'd3:    entry = 16'h40D0;  // COM15: RGB565, full range
            4'd4:    entry = 16'h1101;  // CLKRC: prescale
            4'd5:    entry = 16'h0C00;  // COM3
            4'd6:    entry = 16'h3E00;  // COM14
            4'd7:    entry = 16'h8C00;  // RGB444 off
            4'd8:    entry = 16'h0400;  // COM1
            default: entry = 16'h0000;
        endcase
        return entry;
    endfunction

    state_t               state_r;
    state_t               state_next_s;
    logic [CNT_W-1:0]     cnt_r;
    logic [CNT_W-1:0]     cnt_next_s;
    logic [3:0]           index_r;
    logic [3:0]           index_next_s;
    logic [RETRY_W-1:0]   retry_r;
    logic [RETRY_W-1:0]   retry_next_s;
    logic                 ack_r;
    logic                 ack_next_s;
    logic                 done_r;
    logic                 done_next_s;
    logic                 error_r;
    logic                 error_next_s;
    logic [15:0]          entry_s;
    state_t               adv_state_s;
    logic [3:0]           adv_index_s;
    logic [7:0]           tdata_next_s;

    logic                 cmd_valid_r;
    logic                 cmd_wm_r;
    logic                 cmd_stop_r;
    logic                 data_tvalid_r;
    logic [7:0]           data_tdata_r;
    logic                 data_tlast_r;
    logic                 seq_busy_r;

    assign entry_s = table_entry(index_r);

    // Where a completed entry leads: the next index, or DONE after the last.
    always_comb begin
        if (index_r == LAST_INDEX) begin
            adv_state_s = DONE;
            adv_index_s = index_r;
        end else begin
            adv_state_s = FETCH;
            adv_index_s = index_r + 4'd1;
        end
    end

    // Next-state, counters, retry bookkeeping and sticky status flags.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = '0;
        index_next_s = index_r;
        retry_next_s = retry_r;
        ack_next_s   = ack_r;
        done_next_s  = done_r;
        error_next_s = error_r;

        case (state_r)
            IDLE, DONE, ERROR: begin
                if (start) begin
                    state_next_s = FETCH;
                    index_next_s = 4'd0;
                    retry_next_s = '0;
                    done_next_s  = 1'b0;
                    error_next_s = 1'b0;
                end else begin
                    state_next_s = state_r;
                end
            end
            PWRUP_WAIT: begin
                if (cnt_r == PWRUP_LAST) begin
                    state_next_s = FETCH;
                end else begin
                    cnt_next_s = cnt_r + CNT_W'(1);
                end
            end
            FETCH: begin
                if (entry_s[15:8] == DELAY_MARKER) begin
                    state_next_s = DELAY;
                end else begin
                    state_next_s = SEND_CMD;
                    ack_next_s   = 1'b0;
                end
            end
            SEND_CMD: begin
                ack_next_s = ack_r | i2c_missed_ack;
                if (cmd_valid_r && cmd_ready) begin
                    state_next_s = SEND_REG;
                end else begin
                    state_next_s = SEND_CMD;
                end
            end
            SEND_REG: begin
                ack_next_s = ack_r | i2c_missed_ack;
                if (data_tvalid_r && data_tready) begin
                    state_next_s = SEND_VAL;
                end else begin
                    state_next_s = SEND_REG;
                end
            end
            SEND_VAL: begin
                ack_next_s = ack_r | i2c_missed_ack;
                if (data_tvalid_r && data_tready) begin
                    state_next_s = WAIT_BUSY;
                end else begin
                    state_next_s = SEND_VAL;
                end
            end
            WAIT_BUSY: begin
                // The master may raise busy a cycle late, so never leave on
                // the first cycle; cnt_r != 0 marks that one cycle has passed.
                ack_next_s = ack_r | i2c_missed_ack;
                if ((cnt_r != '0) && !i2c_busy) begin
                    state_next_s = CHECK;
                end else begin
                    cnt_next_s = CNT_W'(1);
                end
            end
            CHECK: begin
                ack_next_s = ack_r | i2c_missed_ack;
                if (!(ack_r | i2c_missed_ack)) begin
                    state_next_s = adv_state_s;
                    index_next_s = adv_index_s;
                    retry_next_s = '0;
                    done_next_s  = (adv_state_s == DONE);
                end else if (retry_r < RETRY_LIMIT) begin
                    state_next_s = FETCH;
                    retry_next_s = retry_r + RETRY_W'(1);
                end else begin
                    state_next_s = ERROR;
                    error_next_s = 1'b1;
                end
            end
            DELAY: begin
                if (cnt_r == SWRST_LAST) begin
                    state_next_s = adv_state_s;
                    index_next_s = adv_index_s;
                    retry_next_s = '0;
                    done_next_s  = (adv_state_s == DONE);
                end else begin
                    cnt_next_s = cnt_r + CNT_W'(1);
                end
            end
            default: begin
                // Corrupted state encoding: stop and make it visible.
                state_next_s = ERROR;
                error_next_s = 1'b1;
            end
        endcase
    end

    // Data byte presented in the state being entered.
    always_comb begin
        case (state_next_s)
            SEND_REG: tdata_next_s = entry_s[15:8];
            SEND_VAL: tdata_next_s = entry_s[7:0];
            default:  tdata_next_s = 8'h00;
        endcase
    end

    // FSM and bookkeeping registers.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_r <= PWRUP_WAIT;
            cnt_r   <= '0;
            index_r <= 4'd0;
            retry_r <= '0;
            ack_r   <= 1'b0;
            done_r  <= 1'b0;
            error_r <= 1'b0;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
            index_r <= index_next_s;
            retry_r <= retry_next_s;
            ack_r   <= ack_next_s;
            done_r  <= done_next_s;
            error_r <= error_next_s;
        end
    end

    // Output registers, decoded from the state being entered so they are
    // aligned with state_r and cannot glitch.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            cmd_valid_r   <= 1'b0;
            cmd_wm_r      <= 1'b0;
            cmd_stop_r    <= 1'b0;
            data_tvalid_r <= 1'b0;
            data_tdata_r  <= 8'h00;
            data_tlast_r  <= 1'b0;
            seq_busy_r    <= 1'b1;
        end else begin
            cmd_valid_r   <= (state_next_s == SEND_CMD);
            cmd_wm_r      <= (state_next_s == SEND_CMD);
            cmd_stop_r    <= (state_next_s == SEND_CMD);
            data_tvalid_r <= (state_next_s == SEND_REG) || (state_next_s == SEND_VAL);
            data_tdata_r  <= tdata_next_s;
            data_tlast_r  <= (state_next_s == SEND_VAL);
            seq_busy_r    <= !((state_next_s == IDLE) || (state_next_s == DONE) ||
                               (state_next_s == ERROR));
        end
    end

    assign cmd_address        = SLAVE_ADDR;
    assign cmd_start          = 1'b0;
    assign cmd_read           = 1'b0;
    assign cmd_write          = 1'b0;
    assign cmd_write_multiple = cmd_wm_r;
    assign cmd_stop           = cmd_stop_r;
    assign cmd_valid          = cmd_valid_r;
    assign data_tdata         = data_tdata_r;
    assign data_tvalid        = data_tvalid_r;
    assign data_tlast         = data_tlast_r;
    assign seq_busy           = seq_busy_r;
    assign seq_done           = done_r;
    assign seq_error          = error_r;
    assign seq_index          = index_r;

endmodule

// File: tb/tb_ov7670_sccb_init_seq.sv
// ---------------------------------------------------------------------------
// tb_ov7670_sccb_init_seq
//
// Bench for ov7670_sccb_init_seq. A responder process plays the i2c_master:
// it drives ready (always, randomly, or held off), raises busy after each
// completed write and can inject a missed-ACK pulse per table entry. The
// expected list of writes and the final status are derived from the table
// and the per-entry NACK plan alone.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ov7670_sccb_init_seq;

    localparam int PWR        = 16;
    localparam int SWR        = 32;
    localparam int MAXR       = 3;
    localparam int BUSY_FIXED = 4;

    logic       clk = 1'b0;
    logic       reset_ = 1'b0;
    logic       start = 1'b0;
    logic [6:0] cmd_address;
    logic       cmd_start, cmd_read, cmd_write, cmd_write_multiple, cmd_stop;
    logic       cmd_valid;
    logic       cmd_ready = 1'b0;
    logic [7:0] data_tdata;
    logic       data_tvalid;
    logic       data_tready = 1'b0;
    logic       data_tlast;
    logic       i2c_busy = 1'b0;
    logic       i2c_missed_ack = 1'b0;
    logic       seq_busy, seq_done, seq_error;
    logic [3:0] seq_index;

    always #5 clk = ~clk;

    ov7670_sccb_init_seq #(
        .SLAVE_ADDR     (7'h21),
        .POWERUP_CYCLES (PWR),
        .SWRESET_CYCLES (SWR),
        .MAX_RETRY      (MAXR)
    ) dut (
        .clk                (clk),
        .reset_             (reset_),
        .start              (start),
        .cmd_address        (cmd_address),
        .cmd_start          (cmd_start),
        .cmd_read           (cmd_read),
        .cmd_write          (cmd_write),
        .cmd_write_multiple (cmd_write_multiple),
        .cmd_stop           (cmd_stop),
        .cmd_valid          (cmd_valid),
        .cmd_ready          (cmd_ready),
        .data_tdata         (data_tdata),
        .data_tvalid        (data_tvalid),
        .data_tready        (data_tready),
        .data_tlast         (data_tlast),
        .i2c_busy           (i2c_busy),
        .i2c_missed_ack     (i2c_missed_ack),
        .seq_busy           (seq_busy),
        .seq_done           (seq_done),
        .seq_error          (seq_error),
        .seq_index          (seq_index)
    );

    logic [15:0] tbl [9] = '{16'h1280, 16'hFFFF, 16'h1204, 16'h40D0, 16'h1101,
                             16'h0C00, 16'h3E00, 16'h8C00, 16'h0400};

    int          n_assert = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          ready_mode = 0;   // 0 ready, 1 random, 2 none ready, 3 cmd only
    int          busy_mode  = 0;   // 0 fixed length, 1 random length
    int          nack_plan [9];
    int          attempts  [9];
    logic [15:0] obs_q [$];
    int          cmd_cyc_q [$];
    int          tlast_cyc_q [$];
    logic [15:0] exp_q [$];
    logic        exp_err;
    logic [3:0]  exp_idx;
    int          both_valid_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int idx_of(input logic [15:0] pair);
        int r = -1;
        for (int i = 0; i < 9; i++) begin
            if (tbl[i] == pair && tbl[i][15:8] != 8'hFF) r = i;
        end
        return r;
    endfunction

    // Reference model: every non-marker entry is written once plus once per
    // NACKed attempt; more NACKs than MAX_RETRY stops the table at that entry.
    task automatic build_expected();
        int tries;
        exp_q.delete();
        exp_err = 1'b0;
        exp_idx = 4'd8;
        for (int i = 0; i < 9; i++) begin
            if (!exp_err && tbl[i][15:8] != 8'hFF) begin
                tries = (nack_plan[i] > MAXR) ? MAXR + 1 : nack_plan[i] + 1;
                for (int t = 0; t < tries; t++) exp_q.push_back(tbl[i]);
                if (nack_plan[i] > MAXR) begin
                    exp_err = 1'b1;
                    exp_idx = 4'(i);
                end
            end
        end
    endtask

    // i2c_master stand-in, acting on the falling edge.
    initial begin : responder
        int          busy_left;
        logic        nack_pending;
        int          byte_n;
        logic [7:0]  reg_byte;
        logic [15:0] pair;
        int          idx;
        busy_left = 0; nack_pending = 1'b0; byte_n = 0; reg_byte = 8'h00;
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset_) begin
                busy_left = 0; nack_pending = 1'b0; byte_n = 0;
                i2c_busy = 1'b0; i2c_missed_ack = 1'b0;
                cmd_ready = 1'b0; data_tready = 1'b0;
            end else begin
                i2c_missed_ack = nack_pending;
                nack_pending   = 1'b0;
                i2c_busy       = (busy_left > 0);
                if (busy_left > 0) busy_left--;
                case (ready_mode)
                    0: begin cmd_ready = 1'b1; data_tready = 1'b1; end
                    1: begin
                        cmd_ready   = 1'($urandom_range(0, 1));
                        data_tready = 1'($urandom_range(0, 1));
                    end
                    2: begin cmd_ready = 1'b0; data_tready = 1'b0; end
                    default: begin cmd_ready = 1'b1; data_tready = 1'b0; end
                endcase
                if (cmd_valid && data_tvalid) both_valid_cnt++;
                if (cmd_valid && cmd_ready) begin
                    check("cmd_addr", 32'(cmd_address), 32'h21);
                    check("cmd_flags", 32'({cmd_start, cmd_read, cmd_write,
                                            cmd_write_multiple, cmd_stop}), 32'b00011);
                    cmd_cyc_q.push_back(cyc);
                    byte_n = 0;
                end
                if (data_tvalid && data_tready) begin
                    check("tlast", 32'(data_tlast), 32'(byte_n == 1));
                    if (byte_n == 0) begin
                        reg_byte = data_tdata;
                    end else begin
                        pair = {reg_byte, data_tdata};
                        obs_q.push_back(pair);
                        tlast_cyc_q.push_back(cyc);
                        busy_left = (busy_mode != 0) ? int'($urandom_range(2, 6)) : BUSY_FIXED;
                        idx = idx_of(pair);
                        if (idx >= 0) begin
                            if (attempts[idx] < nack_plan[idx]) nack_pending = 1'b1;
                            attempts[idx]++;
                        end
                    end
                    byte_n++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic clear_run();
        obs_q.delete();
        cmd_cyc_q.delete();
        tlast_cyc_q.delete();
        for (int i = 0; i < 9; i++) attempts[i] = 0;
    endtask

    task automatic wait_finish(input string tag, input int limit);
        logic fin = 1'b0;
        for (int i = 0; i < limit && !fin; i++) begin
            tick();
            fin = seq_done | seq_error;
        end
        check({tag, "_finished"}, 32'(fin), 32'd1);
    endtask

    task automatic compare_run(input string tag);
        check({tag, "_nwrites"}, 32'(obs_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            check({tag, "_write"}, 32'(obs_q[i]), 32'(exp_q[i]));
        check({tag, "_done"}, 32'(seq_done), 32'(!exp_err));
        check({tag, "_error"}, 32'(seq_error), 32'(exp_err));
        check({tag, "_index"}, 32'(seq_index), 32'(exp_idx));
        check({tag, "_busy"}, 32'(seq_busy), 32'd0);
    endtask

    initial begin : main
        int         rel_cyc;
        int         start_cyc;
        logic       found;
        logic [7:0] snap_data;
        logic [6:0] snap_addr;
        logic [15:0] first_entry;

        for (int i = 0; i < 9; i++) nack_plan[i] = 0;
        first_entry = tbl[0];

        // ---------------- reset state ----------------
        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd_valid", 32'(cmd_valid), 32'd0);
        check("rst_data_tvalid", 32'(data_tvalid), 32'd0);
        check("rst_done", 32'(seq_done), 32'd0);
        check("rst_error", 32'(seq_error), 32'd0);
        check("rst_index", 32'(seq_index), 32'd0);
        check("rst_busy", 32'(seq_busy), 32'd1);
        check("rst_addr", 32'(cmd_address), 32'h21);
        check("rst_cmd_flags", 32'({cmd_start, cmd_read, cmd_write,
                                    cmd_write_multiple, cmd_stop}), 32'd0);
        check("rst_tdata", 32'(data_tdata), 32'd0);
        check("rst_tlast", 32'(data_tlast), 32'd0);

        // ---------------- full table, ready always, fixed busy ----------------
        ready_mode = 0; busy_mode = 0;
        clear_run();
        build_expected();
        @(posedge clk);
        #2;
        reset_ = 1'b1;
        rel_cyc = cyc;
        wait_finish("plain", 3000);
        compare_run("plain");
        // Power-up wait, then one cycle each to fetch and present the command.
        check("pwrup_latency", 32'((cmd_cyc_q.size() > 0) ? cmd_cyc_q[0] - rel_cyc : -1),
              32'(PWR + 2));
        // After a write: busy cycles, the cycle busy is seen low, CHECK,
        // FETCH and the command cycle. The delay marker adds its own FETCH
        // plus the soft-reset wait.
        check("gap_after_swreset",
              32'((cmd_cyc_q.size() > 1 && tlast_cyc_q.size() > 0) ?
                  cmd_cyc_q[1] - tlast_cyc_q[0] : -1),
              32'(BUSY_FIXED + 4 + 1 + SWR));
        check("gap_normal",
              32'((cmd_cyc_q.size() > 2 && tlast_cyc_q.size() > 1) ?
                  cmd_cyc_q[2] - tlast_cyc_q[1] : -1),
              32'(BUSY_FIXED + 4));

        // ---------------- stalls, random ready, ignored start ----------------
        ready_mode = 2; busy_mode = 1;
        clear_run();
        build_expected();
        pulse_start();
        check("restart_clears_done", 32'(seq_done), 32'd0);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            found = cmd_valid;
        end
        check("cmd_valid_rise", 32'(found), 32'd1);
        snap_addr = cmd_address;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("cmd_stall_valid", 32'(cmd_valid), 32'd1);
            check("cmd_stall_addr", 32'(cmd_address), 32'(snap_addr));
        end
        ready_mode = 3;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            found = data_tvalid;
        end
        check("data_valid_rise", 32'(found), 32'd1);
        check("data_first_byte", 32'(data_tdata), 32'(first_entry[15:8]));
        snap_data = data_tdata;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("data_stall_valid", 32'(data_tvalid), 32'd1);
            check("data_stall_tdata", 32'(data_tdata), 32'(snap_data));
            check("data_stall_tlast", 32'(data_tlast), 32'd0);
        end
        ready_mode = 1;
        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            tick();
            found = (seq_index == 4'd4);
        end
        check("reach_index4", 32'(found), 32'd1);
        check("busy_mid_seq", 32'(seq_busy), 32'd1);
        pulse_start();
        wait_finish("stall", 5000);
        compare_run("stall");

        // ---------------- persistent NACK at index 3 ----------------
        ready_mode = 0; busy_mode = 0;
        for (int i = 0; i < 9; i++) nack_plan[i] = 0;
        nack_plan[3] = 100;
        clear_run();
        build_expected();
        start_cyc = cyc;
        pulse_start();
        wait_finish("nack3", 3000);
        compare_run("nack3");
        // Start sampled, FETCH, then the command handshake.
        check("start_latency", 32'((cmd_cyc_q.size() > 0) ? cmd_cyc_q[0] - start_cyc : -1),
              32'd3);
        repeat (20) tick();
        check("error_index_frozen", 32'(seq_index), 32'd3);
        check("error_sticky", 32'(seq_error), 32'd1);

        // ---------------- single NACK at index 5 ----------------
        ready_mode = 1; busy_mode = 1;
        for (int i = 0; i < 9; i++) nack_plan[i] = 0;
        nack_plan[5] = 1;
        clear_run();
        build_expected();
        pulse_start();
        wait_finish("nack5", 5000);
        compare_run("nack5");

        // ---------------- random NACK plans ----------------
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 9; i++)
                nack_plan[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
            clear_run();
            build_expected();
            pulse_start();
            wait_finish("random", 8000);
            compare_run("random");
        end

        // ---------------- reset during SEND_REG ----------------
        ready_mode = 0; busy_mode = 0;
        for (int i = 0; i < 9; i++) nack_plan[i] = 0;
        clear_run();
        pulse_start();
        found = 1'b0;
        for (int i = 0; i < 500 && !found; i++) begin
            tick();
            found = (seq_index == 4'd3);
        end
        check("reach_index3", 32'(found), 32'd1);
        ready_mode = 3;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            tick();
            found = data_tvalid && !data_tlast;
        end
        check("in_send_reg", 32'(found), 32'd1);
        check("pre_reset_index", 32'(seq_index), 32'd3);
        reset_ = 1'b0;
        #1;
        check("async_rst_tvalid", 32'(data_tvalid), 32'd0);
        check("async_rst_cmd_valid", 32'(cmd_valid), 32'd0);
        check("async_rst_index", 32'(seq_index), 32'd0);
        check("async_rst_busy", 32'(seq_busy), 32'd1);
        repeat (3) @(posedge clk);
        clear_run();
        ready_mode = 0;
        build_expected();
        @(posedge clk);
        #2;
        reset_ = 1'b1;
        rel_cyc = cyc;
        wait_finish("post_reset", 3000);
        compare_run("post_reset");
        check("pwrup_latency_again",
              32'((cmd_cyc_q.size() > 0) ? cmd_cyc_q[0] - rel_cyc : -1), 32'(PWR + 2));

        check("never_both_valid", 32'(both_valid_cnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
